// File: rtl/fg_prog_pkg.sv
// fg_prog_pkg: shared state/status encodings and default array geometry for
// the floating-gate programming sequencer.
// Optional feature macro: FG_PROG_TUNNEL_EN adds the TUNNEL (global erase) state.
package fg_prog_pkg;

  localparam int FG_ROWS = 50;
  localparam int FG_COLS = 4;
  localparam int FG_DW   = 12;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_MEASURE = 3'd2,
    S_COMPARE = 3'd3,
    S_PULSE   = 3'd4,
`ifdef FG_PROG_TUNNEL_EN
    S_TUNNEL  = 3'd5,
`endif
    S_FINISH  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_TIMEOUT  = 2'd1,
    ST_ERR_ADDR = 2'd2,
    ST_ABORT    = 2'd3
  } status_e;

endpackage

// File: rtl/fg_prog_timer.sv
// fg_prog_timer: loadable down-counter with a zero flag. Loading N gives a
// zero flag N cycles later, so a state that loads N-1 on entry lasts N cycles.
module fg_prog_timer #(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [PW-1:0] i_value,
  output logic          o_zero
);

  logic [PW-1:0] r_count;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - PW'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/fg_prog_sequencer.sv
// fg_prog_sequencer: accepts one program command, selects the cell, then runs
// a settle / measure / compare / inject loop until the target code is reached,
// the pulse budget runs out, or the host aborts. All outputs are registered
// from the next-state value so they line up with the state they belong to.
// Optional feature macro: FG_PROG_TUNNEL_EN (cmd_erase drives a tunnel pulse).
module fg_prog_sequencer
  import fg_prog_pkg::*;
#(
  parameter int ROWS   = FG_ROWS,
  parameter int COLS   = FG_COLS,
  parameter int ROW_AW = 6,
  parameter int COL_AW = 2,
  parameter int DW     = FG_DW,
  parameter int PW     = 16,
  parameter int NP_W   = 8,
  parameter int SETTLE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [ROW_AW-1:0] i_cmd_row,
  input  logic [COL_AW-1:0] i_cmd_col,
  input  logic [DW-1:0]     i_cmd_target,
  input  logic [PW-1:0]     i_cmd_pulse_len,
  input  logic [NP_W-1:0]   i_cmd_max_pulses,
  input  logic              i_cmd_erase,
  input  logic              i_abort,
  output logic [ROW_AW-1:0] o_row_addr,
  output logic [COL_AW-1:0] o_col_addr,
  output logic              o_sel_en,
  output logic              o_prog_en,
  output logic              o_inj_pulse,
  output logic              o_tunnel_en,
  output logic              o_meas_req,
  input  logic              i_meas_ack,
  input  logic [DW-1:0]     i_meas_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_status,
  output logic [NP_W-1:0]   o_pulses_used
);

  state_e          r_state;
  state_e          w_stateNext;
  status_e         r_status;
  status_e         w_finStatus;
  logic [DW-1:0]   r_target;
  logic [DW-1:0]   r_meas;
  logic [PW-1:0]   r_pulseLen;
  logic [NP_W-1:0] r_maxPulses;
  logic            r_addrErr;
  logic            w_accept;
  logic            w_addrBad;
  logic            w_pulseInc;
  logic            w_drive;
  logic            w_tmrLoad;
  logic [PW-1:0]   w_tmrValue;
  logic            w_tmrZero;
  logic [PW-1:0]   w_lenSrc;
  logic [PW-1:0]   w_lenTicks;
  logic            w_erase;

`ifdef FG_PROG_TUNNEL_EN
  assign w_erase = i_cmd_erase;
`else
  logic w_unusedErase;
  assign w_unusedErase = i_cmd_erase;
  assign w_erase       = 1'b0;
`endif

  // Widened compares keep the range check meaningful for any geometry.
  assign w_addrBad = ({1'b0, i_cmd_row} >= (ROW_AW+1)'(ROWS)) ||
                     ({1'b0, i_cmd_col} >= (COL_AW+1)'(COLS));

  // A zero pulse length still produces one pulse cycle.
  assign w_lenSrc   = (r_state == S_IDLE) ? i_cmd_pulse_len : r_pulseLen;
  assign w_lenTicks = (w_lenSrc == '0) ? '0 : w_lenSrc - PW'(1);

  fg_prog_timer #(.PW(PW)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_tmrLoad),
    .i_value (w_tmrValue),
    .o_zero  (w_tmrZero)
  );

  // Next-state decode, timer loads and completion code; abort overrides all.
  always_comb begin
    w_stateNext = r_state;
    w_finStatus = ST_OK;
    w_accept    = 1'b0;
    w_pulseInc  = 1'b0;
    w_tmrLoad   = 1'b0;
    w_tmrValue  = '0;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          w_accept = 1'b1;
          if (w_erase) begin
`ifdef FG_PROG_TUNNEL_EN
            w_stateNext = S_TUNNEL;
            w_tmrLoad   = 1'b1;
            w_tmrValue  = w_lenTicks;
`endif
          end else if (w_addrBad) begin
            // Bad address takes one quiet COMPARE cycle before FINISH.
            w_stateNext = S_COMPARE;
          end else begin
            w_stateNext = S_SELECT;
            w_tmrLoad   = 1'b1;
            w_tmrValue  = PW'(SETTLE - 1);
          end
        end
      end
      S_SELECT: begin
        if (w_tmrZero) w_stateNext = S_MEASURE;
      end
      S_MEASURE: begin
        if (i_meas_ack) w_stateNext = S_COMPARE;
      end
      S_COMPARE: begin
        if (r_addrErr) begin
          w_stateNext = S_FINISH;
          w_finStatus = ST_ERR_ADDR;
        end else if (r_meas >= r_target) begin
          w_stateNext = S_FINISH;
          w_finStatus = ST_OK;
        end else if (o_pulses_used == r_maxPulses) begin
          w_stateNext = S_FINISH;
          w_finStatus = ST_TIMEOUT;
        end else begin
          w_stateNext = S_PULSE;
          w_pulseInc  = 1'b1;
          w_tmrLoad   = 1'b1;
          w_tmrValue  = w_lenTicks;
        end
      end
      S_PULSE: begin
        if (w_tmrZero) begin
          w_stateNext = S_SELECT;
          w_tmrLoad   = 1'b1;
          w_tmrValue  = PW'(SETTLE - 1);
        end
      end
`ifdef FG_PROG_TUNNEL_EN
      S_TUNNEL: begin
        if (w_tmrZero) begin
          w_stateNext = S_FINISH;
          w_finStatus = ST_OK;
        end
      end
`endif
      S_FINISH: w_stateNext = S_IDLE;
      default:  w_stateNext = S_IDLE;
    endcase
    // FINISH is already completing, so an abort there has nothing to cancel.
    if (i_abort && (r_state != S_IDLE) && (r_state != S_FINISH)) begin
      w_stateNext = S_FINISH;
      w_finStatus = ST_ABORT;
      w_pulseInc  = 1'b0;
      w_tmrLoad   = 1'b0;
    end
  end

  // The bad-address COMPARE cycle is entered from IDLE and must stay undriven.
  assign w_drive = (w_stateNext inside {S_SELECT, S_MEASURE, S_PULSE}) ||
                   ((w_stateNext == S_COMPARE) && (r_state == S_MEASURE));

  // State register plus the latched command and measurement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_target    <= '0;
      r_pulseLen  <= '0;
      r_maxPulses <= '0;
      r_addrErr   <= 1'b0;
      r_meas      <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_accept) begin
        r_target    <= i_cmd_target;
        r_pulseLen  <= i_cmd_pulse_len;
        r_maxPulses <= i_cmd_max_pulses;
        r_addrErr   <= w_addrBad && !w_erase;
      end
      if ((r_state == S_MEASURE) && i_meas_ack) r_meas <= i_meas_data;
    end
  end

  // Registered outputs, each derived from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cmd_ready   <= 1'b1;
      o_busy        <= 1'b0;
      o_sel_en      <= 1'b0;
      o_prog_en     <= 1'b0;
      o_inj_pulse   <= 1'b0;
      o_meas_req    <= 1'b0;
      o_done        <= 1'b0;
      o_row_addr    <= '0;
      o_col_addr    <= '0;
      o_pulses_used <= '0;
      r_status      <= ST_OK;
    end else begin
      o_cmd_ready <= (w_stateNext == S_IDLE);
      o_busy      <= (w_stateNext != S_IDLE);
      o_sel_en    <= w_drive;
      o_prog_en   <= w_drive;
      o_inj_pulse <= (w_stateNext == S_PULSE);
      o_meas_req  <= (w_stateNext == S_MEASURE);
      o_done      <= (w_stateNext == S_FINISH);
      if (w_stateNext == S_FINISH) r_status <= w_finStatus;
      if ((r_state == S_IDLE) && (w_stateNext == S_SELECT)) begin
        o_row_addr <= i_cmd_row;
        o_col_addr <= i_cmd_col;
      end else if (w_stateNext == S_FINISH) begin
        o_row_addr <= '0;
        o_col_addr <= '0;
      end
      if (w_accept) begin
        o_pulses_used <= w_erase ? NP_W'(1) : '0;
      end else if (w_pulseInc) begin
        o_pulses_used <= o_pulses_used + NP_W'(1);
      end
    end
  end

`ifdef FG_PROG_TUNNEL_EN
  // Tunnel pulse follows the TUNNEL state; sel_en stays low there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_tunnel_en <= 1'b0;
    end else begin
      o_tunnel_en <= (w_stateNext == S_TUNNEL);
    end
  end
`else
  assign o_tunnel_en = 1'b0;
`endif

  assign o_status = r_status;

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// tb_fg_prog_sequencer: directed checks of the programming sequencer with a
// one-cycle-latency ADC model and an activity monitor sampling on negedge.
module tb_fg_prog_sequencer;

  logic        clk;
  logic        rstN;
  logic        cmdValid;
  logic        cmdReady;
  logic [5:0]  cmdRow;
  logic [1:0]  cmdCol;
  logic [11:0] cmdTarget;
  logic [15:0] cmdPulseLen;
  logic [7:0]  cmdMaxPulses;
  logic        cmdErase;
  logic        abortIn;
  logic [5:0]  rowAddr;
  logic [1:0]  colAddr;
  logic        selEn;
  logic        progEn;
  logic        injPulse;
  logic        tunnelEn;
  logic        measReq;
  logic        measAck;
  logic [11:0] measData;
  logic        busy;
  logic        done;
  logic [1:0]  status;
  logic [7:0]  pulsesUsed;

  int checks   = 0;
  int failures = 0;

  int cyc = 0, pulseTotal = 0, measTotal = 0, lastLen = 0, curLen = 0;
  int selTotal = 0, mreqTotal = 0, overlapTotal = 0, ackCyc = 0, doneCyc = 0;
  bit prevInj = 0;
  bit adcEnable = 1;
  logic [11:0] adcQ[$];

  int pBase, mBase, sBase, rBase, n;

  fg_prog_sequencer dut (
    .clk              (clk),
    .rst_n            (rstN),
    .i_cmd_valid      (cmdValid),
    .o_cmd_ready      (cmdReady),
    .i_cmd_row        (cmdRow),
    .i_cmd_col        (cmdCol),
    .i_cmd_target     (cmdTarget),
    .i_cmd_pulse_len  (cmdPulseLen),
    .i_cmd_max_pulses (cmdMaxPulses),
    .i_cmd_erase      (cmdErase),
    .i_abort          (abortIn),
    .o_row_addr       (rowAddr),
    .o_col_addr       (colAddr),
    .o_sel_en         (selEn),
    .o_prog_en        (progEn),
    .o_inj_pulse      (injPulse),
    .o_tunnel_en      (tunnelEn),
    .o_meas_req       (measReq),
    .i_meas_ack       (measAck),
    .i_meas_data      (measData),
    .o_busy           (busy),
    .o_done           (done),
    .o_status         (status),
    .o_pulses_used    (pulsesUsed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Activity monitor and ADC model share one process so cycle stamps agree.
  initial begin
    measAck  = 1'b0;
    measData = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (injPulse) begin
        curLen++;
        if (!prevInj) pulseTotal++;
      end else if (prevInj) begin
        lastLen = curLen;
        curLen  = 0;
      end
      prevInj = injPulse;
      if (selEn || progEn) selTotal++;
      if (measReq) mreqTotal++;
      if (measReq && injPulse) overlapTotal++;
      if (done) doneCyc = cyc;
      if (measAck) begin
        measAck = 1'b0;
      end else if (measReq && adcEnable) begin
        measAck  = 1'b1;
        measData = (adcQ.size() > 0) ? adcQ.pop_front() : 12'h000;
        measTotal++;
        ackCyc = cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] row, input logic [1:0] col,
                               input logic [11:0] target, input logic [15:0] len,
                               input logic [7:0] maxP);
    cmdRow       = row;
    cmdCol       = col;
    cmdTarget    = target;
    cmdPulseLen  = len;
    cmdMaxPulses = maxP;
    cmdValid     = 1'b1;
    step();
    cmdValid = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      step();
      k++;
    end
    checkOutput(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic snapshot();
    pBase = pulseTotal;
    mBase = measTotal;
    sBase = selTotal;
    rBase = mreqTotal;
  endtask

  initial begin
    rstN = 1'b0; cmdValid = 1'b0; cmdRow = '0; cmdCol = '0; cmdTarget = '0;
    cmdPulseLen = '0; cmdMaxPulses = '0; cmdErase = 1'b0; abortIn = 1'b0;
    repeat (3) step();
    checkOutput("rst_ready", {31'd0, cmdReady}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_sel", {31'd0, selEn}, 32'd0);
    checkOutput("rst_status", {30'd0, status}, 32'd0);
    checkOutput("rst_pulses", {24'd0, pulsesUsed}, 32'd0);
    rstN = 1'b1;
    step();

    // Program hit: two five-cycle pulses, then OK.
    adcQ = '{12'h300, 12'h380, 12'h410};
    snapshot();
    applyStimulus(6'd10, 2'd2, 12'h400, 16'd5, 8'd8);
    checkOutput("hit_sel1", {31'd0, selEn}, 32'd1);
    checkOutput("hit_prog1", {31'd0, progEn}, 32'd1);
    checkOutput("hit_ready0", {31'd0, cmdReady}, 32'd0);
    checkOutput("hit_row", {26'd0, rowAddr}, 32'd10);
    checkOutput("hit_col", {30'd0, colAddr}, 32'd2);
    n = 0;
    while (!measReq && n < 100) begin
      step();
      n++;
    end
    checkOutput("hit_settle", n, 32'd8);
    waitDone("hit_done", 400);
    checkOutput("hit_status", {30'd0, status}, 32'd0);
    checkOutput("hit_pulses_used", {24'd0, pulsesUsed}, 32'd2);
    checkOutput("hit_pulse_cnt", pulseTotal - pBase, 32'd2);
    checkOutput("hit_pulse_len", lastLen, 32'd5);
    checkOutput("hit_meas_cnt", measTotal - mBase, 32'd3);
    checkOutput("hit_ack2done", doneCyc - ackCyc, 32'd2);
    checkOutput("hit_sel_fin", {31'd0, selEn}, 32'd0);
    step();
    checkOutput("hit_ready1", {31'd0, cmdReady}, 32'd1);
    checkOutput("hit_done_strobe", {31'd0, done}, 32'd0);

    // Timeout: budget of three pulses never reaches the target.
    adcQ = '{12'h100, 12'h100, 12'h100, 12'h100};
    snapshot();
    applyStimulus(6'd0, 2'd0, 12'hFFF, 16'd2, 8'd3);
    waitDone("to_done", 400);
    checkOutput("to_status", {30'd0, status}, 32'd1);
    checkOutput("to_pulses_used", {24'd0, pulsesUsed}, 32'd3);
    checkOutput("to_pulse_cnt", pulseTotal - pBase, 32'd3);
    checkOutput("to_meas_cnt", measTotal - mBase, 32'd4);
    step();
    checkOutput("to_status_held", {30'd0, status}, 32'd1);

    // Bad address: row 50 completes two cycles after accept, nothing driven.
    snapshot();
    applyStimulus(6'd50, 2'd1, 12'h100, 16'd3, 8'd4);
    checkOutput("bad_done_early", {31'd0, done}, 32'd0);
    checkOutput("bad_ready0", {31'd0, cmdReady}, 32'd0);
    step();
    checkOutput("bad_done", {31'd0, done}, 32'd1);
    checkOutput("bad_status", {30'd0, status}, 32'd2);
    checkOutput("bad_sel_cnt", selTotal - sBase, 32'd0);
    checkOutput("bad_mreq_cnt", mreqTotal - rBase, 32'd0);
    step();
    checkOutput("bad_ready1", {31'd0, cmdReady}, 32'd1);

    // Abort on the third cycle of the first injection pulse.
    adcQ = '{12'h100};
    applyStimulus(6'd20, 2'd3, 12'hFFF, 16'd5, 8'd8);
    n = 0;
    while (!injPulse && n < 100) begin
      step();
      n++;
    end
    checkOutput("abort_pulse_seen", {31'd0, injPulse}, 32'd1);
    step();
    step();
    abortIn = 1'b1;
    step();
    abortIn = 1'b0;
    checkOutput("abort_inj", {31'd0, injPulse}, 32'd0);
    checkOutput("abort_sel", {31'd0, selEn}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd1);
    checkOutput("abort_status", {30'd0, status}, 32'd3);
    checkOutput("abort_pulses_used", {24'd0, pulsesUsed}, 32'd1);
    step();
    checkOutput("abort_ready", {31'd0, cmdReady}, 32'd1);

    // pulse_len 0 still gives a single one-cycle pulse.
    adcQ = '{12'h100, 12'h500};
    snapshot();
    applyStimulus(6'd49, 2'd3, 12'h400, 16'd0, 8'd8);
    waitDone("len0_done", 400);
    checkOutput("len0_status", {30'd0, status}, 32'd0);
    checkOutput("len0_pulse_cnt", pulseTotal - pBase, 32'd1);
    checkOutput("len0_pulse_len", lastLen, 32'd1);
    checkOutput("len0_pulses_used", {24'd0, pulsesUsed}, 32'd1);
    step();

    // max_pulses 0: one measurement and no pulse.
    adcQ = '{12'h000};
    snapshot();
    applyStimulus(6'd5, 2'd1, 12'h100, 16'd4, 8'd0);
    waitDone("max0_done", 400);
    checkOutput("max0_status", {30'd0, status}, 32'd1);
    checkOutput("max0_pulse_cnt", pulseTotal - pBase, 32'd0);
    checkOutput("max0_meas_cnt", measTotal - mBase, 32'd1);
    checkOutput("max0_overlap", overlapTotal, 32'd0);
    step();

    // Reset while waiting in MEASURE clears outputs without a clock edge.
    adcEnable = 1'b0;
    applyStimulus(6'd3, 2'd1, 12'h800, 16'd4, 8'd2);
    n = 0;
    while (!measReq && n < 100) begin
      step();
      n++;
    end
    checkOutput("rstm_mreq_seen", {31'd0, measReq}, 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rstm_mreq", {31'd0, measReq}, 32'd0);
    checkOutput("rstm_sel", {31'd0, selEn}, 32'd0);
    checkOutput("rstm_prog", {31'd0, progEn}, 32'd0);
    checkOutput("rstm_busy", {31'd0, busy}, 32'd0);
    step();
    rstN = 1'b1;
    adcEnable = 1'b1;
    step();
    checkOutput("rstm_ready", {31'd0, cmdReady}, 32'd1);
    checkOutput("rstm_status", {30'd0, status}, 32'd0);
    checkOutput("rstm_pulses_used", {24'd0, pulsesUsed}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
